// File: rtl/tiny8_mem_ctrl.sv
// Memory-side slave for the tiny8 core: 256 x 8 RAM with programmable wait states.
// Optional write protection below PROT_LIMIT is built in when TINY8_MEM_WPROT_EN is defined.
module tiny8_mem_ctrl #(
    parameter int unsigned LATENCY    = 2,
    parameter logic [7:0]  PROT_LIMIT = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic        mem_resp,
    output logic [7:0]  mem_rdata,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err,
    output logic        prot_fault,
    output logic [1:0]  state_o
);

    // Handshake: mem_read/mem_write are levels held by the core until mem_resp;
    // they are sampled only in IDLE and mem_resp is a single-cycle completion pulse.

`ifdef TINY8_MEM_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    localparam logic [3:0] LAT_W = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        is_wr_q;
    logic [7:0]  ram [256];

    logic        enter_resp;
    logic        wprot_hit;
    logic        blocked;
    logic        commit;

    // The accept edge always lands in WAIT; the counter then burns LATENCY
    // cycles so RESP is entered LATENCY+1 edges after acceptance.
    assign enter_resp = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign wprot_hit  = is_wr_q && (addr_q < PROT_LIMIT);
    assign blocked    = WPROT_EN && wprot_hit;
    assign commit     = enter_resp && is_wr_q && !blocked;
    assign state_o    = state_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            ram[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            is_wr_q    <= 1'b0;
            mem_resp   <= 1'b0;
            mem_rdata  <= 8'h00;
            busy       <= 1'b0;
            rd_count   <= 16'h0000;
            wr_count   <= 16'h0000;
            proto_err  <= 1'b0;
            prot_fault <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        is_wr_q <= mem_write;
                        cnt_q   <= LAT_W;
                        state_q <= S_WAIT;
                        busy    <= 1'b1;
                        if (mem_read && mem_write) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= S_RESP;
                        mem_resp <= 1'b1;
                        if (is_wr_q) begin
                            if (wr_count != 16'hFFFF) begin
                                wr_count <= wr_count + 16'd1;
                            end
                            if (blocked) begin
                                prot_fault <= 1'b1;
                            end
                        end else begin
                            mem_rdata <= ram[addr_q];
                            if (rd_count != 16'hFFFF) begin
                                rd_count <= rd_count + 16'd1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny8_mem_ctrl.sv
// Self-checking bench for tiny8_mem_ctrl: two instances (LATENCY 2 and 0) driven
// with directed and random accesses against a transaction-level RAM model.
module tb_tiny8_mem_ctrl;

    localparam int N_DUT = 2;

`ifdef TINY8_MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read   [N_DUT];
    logic        mem_write  [N_DUT];
    logic [7:0]  mem_addr   [N_DUT];
    logic [7:0]  mem_wdata  [N_DUT];
    logic        mem_resp   [N_DUT];
    logic [7:0]  mem_rdata  [N_DUT];
    logic        busy       [N_DUT];
    logic [15:0] rd_count   [N_DUT];
    logic [15:0] wr_count   [N_DUT];
    logic        proto_err  [N_DUT];
    logic        prot_fault [N_DUT];
    logic [1:0]  state_o    [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        tiny8_mem_ctrl #(.LATENCY((g == 0) ? 2 : 0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_resp  (mem_resp[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g]),
            .rd_count  (rd_count[g]),
            .wr_count  (wr_count[g]),
            .proto_err (proto_err[g]),
            .prot_fault(prot_fault[g]),
            .state_o   (state_o[g])
        );
    end

    // Reference model: RAM image, known-location map, counters and flags.
    logic [7:0] ram_m      [N_DUT][256];
    bit         known_m    [N_DUT][256];
    int         rd_m       [N_DUT];
    int         wr_m       [N_DUT];
    bit         perr_m     [N_DUT];
    bit         pf_m       [N_DUT];
    logic [7:0] rdata_m    [N_DUT];
    bit         rdata_ok_m [N_DUT];
    logic [7:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N_DUT; d++) begin
            rd_m[d]       = 0;
            wr_m[d]       = 0;
            perr_m[d]     = 1'b0;
            pf_m[d]       = 1'b0;
            rdata_m[d]    = 8'h00;
            rdata_ok_m[d] = 1'b1;
        end
    endtask

    task automatic check_status(input int d);
        check("rd_count", rd_count[d], sat16(rd_m[d]));
        check("wr_count", wr_count[d], sat16(wr_m[d]));
        check("proto_err", proto_err[d], perr_m[d]);
        check("prot_fault", prot_fault[d], pf_m[d]);
    endtask

    task automatic release_req(input int d);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        mem_addr[d]  = 8'($urandom);
        mem_wdata[d] = 8'($urandom);
    endtask

    // hold < 0 keeps the request up through the RESP cycle and the edge after it.
    task automatic access(input int d, input bit rd, input bit wr,
                          input logic [7:0] a, input logic [7:0] wd, input int hold);
        int lat;
        bit blk;
        bit chk_data;
        logic [7:0] exp_d;
        lat      = lat_of(d);
        blk      = wr && WPROT && (a < 8'h40);
        chk_data = 1'b0;
        if (rd && wr) perr_m[d] = 1'b1;
        if (!wr && known_m[d][a]) begin
            exp_q.push_back(ram_m[d][a]);
            chk_data = 1'b1;
        end

        @(negedge clk);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        mem_addr[d]  = a;
        mem_wdata[d] = wd;
        @(posedge clk);
        #1;
        check("resp_at_accept", mem_resp[d], 1'b0);
        check("busy_after_accept", busy[d], 1'b1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (hold >= 0 && k > hold) release_req(d);
            @(posedge clk);
            #1;
            check((k == lat + 1) ? "resp_pulse" : "resp_early", mem_resp[d], (k == lat + 1));
            check("busy_in_flight", busy[d], 1'b1);
        end

        if (wr) begin
            wr_m[d]++;
            if (blk) pf_m[d] = 1'b1;
            else begin
                ram_m[d][a]   = wd;
                known_m[d][a] = 1'b1;
            end
        end else begin
            rd_m[d]++;
            rdata_ok_m[d] = known_m[d][a];
            rdata_m[d]    = ram_m[d][a];
        end
        if (chk_data) begin
            exp_d = exp_q.pop_front();
            check("rdata", mem_rdata[d], exp_d);
        end else if (wr && rdata_ok_m[d]) begin
            check("rdata_hold", mem_rdata[d], rdata_m[d]);
        end
        check_status(d);

        @(negedge clk);
        if (hold >= 0) release_req(d);
        @(posedge clk);
        #1;
        check("resp_single", mem_resp[d], 1'b0);
        check("no_double_accept", busy[d], 1'b0);
        @(negedge clk);
        release_req(d);
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < N_DUT; d++) begin
            check("rst_resp", mem_resp[d], 1'b0);
            check("rst_rdata", mem_rdata[d], 8'h00);
            check("rst_busy", busy[d], 1'b0);
            check("rst_state", state_o[d], 2'd0);
            check_status(d);
        end
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        mem_write[0] = 1'b1;
        mem_addr[0]  = 8'hA0;
        mem_wdata[0] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        release_req(0);
        #1;
        check("rst_async_busy", busy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("rst_no_resp", mem_resp[0], 1'b0);
        end
        check_reset_state();
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            release_req(d);
            for (int a = 0; a < 256; a++) known_m[d][a] = 1'b0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back on the LATENCY=2 instance.
        access(0, 1'b0, 1'b1, 8'h80, 8'hA5, -1);
        access(0, 1'b1, 1'b0, 8'h80, 8'h00, -1);

        // Zero-latency instance with the read held through RESP.
        access(1, 1'b0, 1'b1, 8'h80, 8'h5A, -1);
        access(1, 1'b1, 1'b0, 8'h80, 8'h00, -1);

        // Fill both RAM images so every later read has a known answer.
        for (int a = 0; a < 256; a++) begin
            access(0, 1'b0, 1'b1, 8'(a), 8'($urandom), $urandom_range(0, 3));
            access(1, 1'b0, 1'b1, 8'(a), 8'($urandom), $urandom_range(0, 2));
        end

        // Request dropped while waiting still completes.
        access(0, 1'b0, 1'b1, 8'h90, 8'h3C, 1);
        access(0, 1'b1, 1'b0, 8'h90, 8'h00, 0);

        // Simultaneous read and write is a write plus a sticky error.
        access(0, 1'b1, 1'b1, 8'hC0, 8'h11, -1);
        access(0, 1'b1, 1'b0, 8'hC0, 8'h00, -1);
        access(0, 1'b1, 1'b0, 8'h81, 8'h00, 2);

        for (int i = 0; i < 120; i++) begin
            int d;
            int op;
            d  = $urandom_range(0, N_DUT - 1);
            op = $urandom_range(0, 9);
            access(d, (op == 0) || (op > 4), (op <= 4), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 4) - 1);
        end

        reset_mid_wait();
        access(0, 1'b1, 1'b0, 8'hA0, 8'h00, -1);

`ifdef TINY8_MEM_WPROT_EN
        access(0, 1'b0, 1'b1, 8'h10, 8'h55, -1);
        access(0, 1'b0, 1'b1, 8'h40, 8'h77, -1);
        access(0, 1'b1, 1'b0, 8'h40, 8'h00, -1);
        access(0, 1'b1, 1'b0, 8'h10, 8'h00, -1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
